// File: rtl/warp_scheduler_pkg.sv
// ============================================================================
// Package    : Structs_and_Params
// Description: Shared kernel descriptor, idle constants and scheduler states.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package Structs_and_Params;

   localparam int THREAD_COUNT_W = 8;

   typedef struct packed {
      logic [3:0]                warp_id;
      logic [THREAD_COUNT_W-1:0] thread_count;
      logic [31:0]               start_pc;
   } kernel_t;

   localparam logic [3:0] IDLE_WARP_ID = 4'hF;
   localparam kernel_t    IDLE_KERNEL  = '{warp_id: IDLE_WARP_ID, thread_count: '0, start_pc: '0};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/warp_scheduler_fifo.sv
// ============================================================================
// Module     : warp_fifo
// Description: Synchronous FIFO of kernel_t launch descriptors.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_fifo
   import Structs_and_Params::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  kernel_t                push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output kernel_t                head
);

   localparam int AW = $clog2(DEPTH);

   kernel_t     mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   // The extra pointer MSB separates a full queue from an empty one.
   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/warp_scheduler.sv
// ============================================================================
// Module     : warp_scheduler
// Description: Queues warp launches and feeds them one at a time to simd_core.
//              Optional watchdog retirement enabled by WARP_SCHED_TIMEOUT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_scheduler
   import Structs_and_Params::*;
#(
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         launch_valid,
   output logic                         launch_ready,
   input  kernel_t                      launch_kernel,
   output kernel_t                      core_kernel,
   input  logic                         core_is_finished,
   input  logic [3:0]                   core_finished_warp_id,
   output logic                         done_valid,
   output logic [3:0]                   done_warp_id,
   output logic                         done_timeout,
   output logic                         busy,
   output logic [$clog2(QUEUE_DEPTH):0] pending_count,
   output logic                         err_sticky
);

   sched_state_t state, state_next;
   kernel_t      core_kernel_next;
   logic [3:0]   active_id, active_id_next;
   logic         done_valid_next;
   logic [3:0]   done_warp_id_next;
   logic         done_timeout_next;
   logic         err_next;
   logic         accept;
   logic         fifo_push;
   logic         fifo_pop;
   logic         fifo_full;
   logic         fifo_empty;
   kernel_t      fifo_head;
   logic         finish_match;

   assign launch_ready = !fifo_full;
   assign accept       = launch_valid && launch_ready;
   // Launches carrying the "no warp" id are swallowed rather than queued.
   assign fifo_push    = accept && (launch_kernel.warp_id != IDLE_WARP_ID);
   assign finish_match = core_is_finished && (core_finished_warp_id == active_id);
   assign busy         = (state != IDLE) || !fifo_empty;

   warp_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (launch_kernel),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (pending_count),
      .head      (fifo_head)
   );

`ifdef WARP_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WD_W-1:0] wd_count, wd_count_next;

   always_ff @(posedge clk) begin
      if (!rst) wd_count <= '0;
      else      wd_count <= wd_count_next;
   end
`endif

   always_comb begin
      state_next        = state;
      core_kernel_next  = core_kernel;
      active_id_next    = active_id;
      done_valid_next   = 1'b0;
      done_warp_id_next = done_warp_id;
      done_timeout_next = 1'b0;
      err_next          = err_sticky;
      fifo_pop          = 1'b0;
`ifdef WARP_SCHED_TIMEOUT_EN
      wd_count_next     = wd_count;
`endif

      if (accept && (launch_kernel.warp_id == IDLE_WARP_ID)) err_next = 1'b1;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop         = 1'b1;
               core_kernel_next = fifo_head;
               active_id_next   = fifo_head.warp_id;
               state_next       = RUN;
`ifdef WARP_SCHED_TIMEOUT_EN
               wd_count_next    = '0;
`endif
            end
         end
         RUN: begin
            if (finish_match) begin
               done_valid_next   = 1'b1;
               done_warp_id_next = active_id;
               core_kernel_next  = IDLE_KERNEL;
               state_next        = DRAIN;
            end else begin
               if (core_is_finished) err_next = 1'b1;
`ifdef WARP_SCHED_TIMEOUT_EN
               if (wd_count == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  done_valid_next   = 1'b1;
                  done_warp_id_next = active_id;
                  done_timeout_next = 1'b1;
                  err_next          = 1'b1;
                  core_kernel_next  = IDLE_KERNEL;
                  state_next        = DRAIN;
               end else begin
                  wd_count_next = wd_count + 1'b1;
               end
`endif
            end
         end
         // One idle-kernel cycle so the core sees a change even for a repeated id.
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         core_kernel  <= IDLE_KERNEL;
         active_id    <= IDLE_WARP_ID;
         done_valid   <= 1'b0;
         done_warp_id <= 4'h0;
         done_timeout <= 1'b0;
         err_sticky   <= 1'b0;
      end else begin
         state        <= state_next;
         core_kernel  <= core_kernel_next;
         active_id    <= active_id_next;
         done_valid   <= done_valid_next;
         done_warp_id <= done_warp_id_next;
         done_timeout <= done_timeout_next;
         err_sticky   <= err_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_warp_scheduler.sv
// Directed self-checking bench for warp_scheduler (QUEUE_DEPTH=4, TIMEOUT_CYCLES=16).
`default_nettype none

module tb_warp_scheduler;
   import Structs_and_Params::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       launch_valid;
   logic       launch_ready;
   kernel_t    launch_kernel;
   kernel_t    core_kernel;
   logic       core_is_finished;
   logic [3:0] core_finished_warp_id;
   logic       done_valid;
   logic [3:0] done_warp_id;
   logic       done_timeout;
   logic       busy;
   logic [2:0] pending_count;
   logic       err_sticky;

   int errors = 0;
   int checks = 0;

   warp_scheduler #(
      .QUEUE_DEPTH    (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .launch_valid          (launch_valid),
      .launch_ready          (launch_ready),
      .launch_kernel         (launch_kernel),
      .core_kernel           (core_kernel),
      .core_is_finished      (core_is_finished),
      .core_finished_warp_id (core_finished_warp_id),
      .done_valid            (done_valid),
      .done_warp_id          (done_warp_id),
      .done_timeout          (done_timeout),
      .busy                  (busy),
      .pending_count         (pending_count),
      .err_sticky            (err_sticky)
   );

   always #5 clk = ~clk;

   function automatic kernel_t mk(input int id);
      kernel_t k;
      k.warp_id      = 4'(id);
      k.thread_count = 8'(id);
      k.start_pc     = {4'(id), 28'h0000100};
      return k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic finish_with(input int id);
      core_is_finished      = 1'b1;
      core_finished_warp_id = 4'(id);
      tick();
      core_is_finished      = 1'b0;
      core_finished_warp_id = 4'h0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_kernel"}, 64'(core_kernel), 64'(IDLE_KERNEL));
      chk({tag, "_done"}, 64'(done_valid), 64'd0);
      chk({tag, "_done_id"}, 64'(done_warp_id), 64'd0);
      chk({tag, "_timeout"}, 64'(done_timeout), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_pending"}, 64'(pending_count), 64'd0);
      chk({tag, "_err"}, 64'(err_sticky), 64'd0);
      chk({tag, "_ready"}, 64'(launch_ready), 64'd1);
   endtask

   initial begin
      kernel_t k1;
      rst                   = 1'b0;
      launch_valid          = 1'b0;
      launch_kernel         = IDLE_KERNEL;
      core_is_finished      = 1'b0;
      core_finished_warp_id = 4'h0;
      tick();
      tick();
      chk_reset_state("reset");

      // First launch: visible on core_kernel after the second edge post-accept.
      rst = 1'b1;
      tick();
      k1.warp_id = 4'd1; k1.thread_count = 8'd4; k1.start_pc = 32'h1234_5678;
      launch_valid  = 1'b1;
      launch_kernel = k1;
      tick();
      launch_valid = 1'b0;
      chk("accept_kernel_idle", 64'(core_kernel), 64'(IDLE_KERNEL));
      chk("accept_pending", 64'(pending_count), 64'd1);
      chk("accept_busy", 64'(busy), 64'd1);
      tick();
      chk("dispatch1_kernel", 64'(core_kernel), 64'(k1));
      chk("dispatch1_pending", 64'(pending_count), 64'd0);
      chk("dispatch1_busy", 64'(busy), 64'd1);

      // Core finishes id 1 after 5 cycles.
      repeat (4) tick();
      chk("run1_no_done", 64'(done_valid), 64'd0);
      finish_with(1);
      chk("retire1_done", 64'(done_valid), 64'd1);
      chk("retire1_id", 64'(done_warp_id), 64'd1);
      chk("retire1_timeout", 64'(done_timeout), 64'd0);
      chk("drain1_kernel", 64'(core_kernel), 64'(IDLE_KERNEL));
      tick();
      chk("post1_done", 64'(done_valid), 64'd0);
      chk("post1_busy", 64'(busy), 64'd0);

      // Ids 2..6 back to back with the core stalled.
      launch_valid = 1'b1;
      for (int i = 2; i <= 6; i++) begin
         launch_kernel = mk(i);
         tick();
      end
      chk("fill_kernel", 64'(core_kernel), 64'(mk(2)));
      chk("fill_pending", 64'(pending_count), 64'd4);
      chk("fill_ready", 64'(launch_ready), 64'd0);
      launch_kernel = mk(9);
      tick();
      launch_valid = 1'b0;
      chk("full_reject_pending", 64'(pending_count), 64'd4);

      // Mismatched finish is ignored but flagged.
      finish_with(7);
      chk("mismatch_done", 64'(done_valid), 64'd0);
      chk("mismatch_err", 64'(err_sticky), 64'd1);
      chk("mismatch_held", 64'(core_kernel), 64'(mk(2)));
      finish_with(2);
      chk("retire2_done", 64'(done_valid), 64'd1);
      chk("retire2_id", 64'(done_warp_id), 64'd2);
      chk("drain2_pending", 64'(pending_count), 64'd4);
      tick();
      chk("idle2_kernel", 64'(core_kernel), 64'(IDLE_KERNEL));
      chk("idle2_ready", 64'(launch_ready), 64'd0);
      tick();
      chk("dispatch3_kernel", 64'(core_kernel), 64'(mk(3)));
      chk("dispatch3_pending", 64'(pending_count), 64'd3);
      chk("dispatch3_ready", 64'(launch_ready), 64'd1);

      for (int k = 3; k <= 6; k++) begin
         finish_with(k);
         chk("retire_loop_done", 64'(done_valid), 64'd1);
         chk("retire_loop_id", 64'(done_warp_id), 64'(k));
         tick();
         tick();
         if (k < 6) begin
            chk("dispatch_loop_kernel", 64'(core_kernel), 64'(mk(k + 1)));
            chk("dispatch_loop_pending", 64'(pending_count), 64'(5 - k));
         end
      end
      chk("drained_busy", 64'(busy), 64'd0);
      chk("drained_kernel", 64'(core_kernel), 64'(IDLE_KERNEL));

      // Reset in the middle of RUN with a warp queued behind.
      launch_valid  = 1'b1;
      launch_kernel = mk(8);
      tick();
      launch_kernel = mk(9);
      tick();
      launch_valid = 1'b0;
      chk("mid_run_kernel", 64'(core_kernel), 64'(mk(8)));
      chk("mid_run_pending", 64'(pending_count), 64'd1);
      rst = 1'b0;
      tick();
      chk_reset_state("mid_run_reset");
      rst = 1'b1;
      tick();

      // Launch of the idle id: accepted, discarded, flagged.
      launch_valid  = 1'b1;
      launch_kernel = IDLE_KERNEL;
      launch_kernel.thread_count = 8'd3;
      chk("idle_id_ready", 64'(launch_ready), 64'd1);
      tick();
      launch_valid = 1'b0;
      chk("idle_id_err", 64'(err_sticky), 64'd1);
      chk("idle_id_pending", 64'(pending_count), 64'd0);
      tick();
      chk("idle_id_kernel", 64'(core_kernel), 64'(IDLE_KERNEL));
      chk("idle_id_busy", 64'(busy), 64'd0);

`ifdef WARP_SCHED_TIMEOUT_EN
      // Watchdog: retire exactly 16 cycles after RUN entry, then dispatch next.
      launch_valid  = 1'b1;
      launch_kernel = mk(10);
      tick();
      launch_kernel = mk(11);
      tick();
      launch_valid = 1'b0;
      chk("wd_dispatch", 64'(core_kernel), 64'(mk(10)));
      repeat (15) tick();
      chk("wd_not_yet", 64'(done_valid), 64'd0);
      tick();
      chk("wd_done", 64'(done_valid), 64'd1);
      chk("wd_timeout", 64'(done_timeout), 64'd1);
      chk("wd_id", 64'(done_warp_id), 64'd10);
      chk("wd_kernel_idle", 64'(core_kernel), 64'(IDLE_KERNEL));
      tick();
      tick();
      chk("wd_next_dispatch", 64'(core_kernel), 64'(mk(11)));
`else
      // Without the watchdog a stalled warp stays on the core.
      launch_valid  = 1'b1;
      launch_kernel = mk(10);
      tick();
      launch_valid = 1'b0;
      repeat (40) tick();
      chk("no_wd_done", 64'(done_valid), 64'd0);
      chk("no_wd_held", 64'(core_kernel), 64'(mk(10)));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
